dispatcher_ctrl: RTL
====================

// Module: dispatcher_ctrl
// PURPOSE
//  Sequencer for the Stripes bit-serial dispatcher: drives its per-window brick select,
//  window enable mask and ping-pong buffer select. Accepts NM rows from memory (valid/ready),
//  fills one transposer buffer window-by-window while the other streams P bit-planes
//  downstream. Runs one pass of i_groups brick-groups per i_start, then pulses o_done.
// PARAMETERS
//  BRICKS_PER_ROW   16  bricks per NM row (select range)
//  PARALLEL_WINDOWS 16  windows (transposers) per buffer
//  SEL_BITS         4   clog2(BRICKS_PER_ROW)
//  WL               16  word length = max precision
//  GRP_BITS         12  width of the brick-group count
// PORTS
//  clk          in   1                     clock, rising edge
//  rst          in   1                     asynchronous, active-high reset
//  i_start      in   1                     start pass; ignored while o_busy
//  i_groups     in   GRP_BITS              brick-groups in pass; 0 = no-op pass
//  i_windows    in   clog2(PW)+1           active windows 1..PW; 0 or >PW treated as PW
//  i_precision  in   clog2(WL)+1           bits streamed per group 1..WL; 0 or >WL treated as WL
//  i_base_brick in   SEL_BITS              brick index for window 0
//  i_stride     in   SEL_BITS              brick step per window
//  i_mem_valid  in   1                     NM row valid on dispatcher i_mem
//  o_mem_ready  out  1                     row accepted when valid&&ready
//  o_sel        out  SEL_BITS*PW           per-window brick select
//  o_enable     out  PW                    one-hot window being written
//  o_read_buf   out  1                     1: fill b0/stream b1; 0: fill b1/stream b0
//  i_stream_rdy in   1                     downstream accepts a bit-plane
//  o_stream_vld out  1                     dispatcher o_stream holds a valid bit-plane
//  o_bit_idx    out  clog2(WL)             bit-plane index of current stream beat (MSB first = P-1)
//  o_busy       out  1                     pass in progress
//  o_done       out  1                     one-cycle pulse at end of pass
// BEHAVIOUR
//  Reset: o_mem_ready=0, o_sel=0, o_enable=0, o_read_buf=0, o_stream_vld=0, o_bit_idx=0,
//   o_busy=0, o_done=0; all counters/flags cleared; reset mid-pass aborts with no o_done.
//  i_start in IDLE latches config (after clamping) and moves to FILL; o_busy=1 next cycle.
//  States: IDLE -> FILL (first group, nothing streaming) -> RUN (fill+stream overlap) ->
//   DRAIN (last group streaming, no fill) -> IDLE. i_groups=0: o_done pulses the cycle after
//   start, o_busy never set. i_groups=1: FILL -> DRAIN.
//  Fill: o_mem_ready=1 while fill buffer not full and groups_loaded<G. Each accepted row writes
//   window w (o_enable=1<<w, combinational from win_cnt&&valid&&ready); win_cnt increments;
//   after W-th row fill_full=1, win_cnt=0, groups_loaded++.
//  o_sel[w] = (base + w*stride) mod BRICKS_PER_ROW, constant for the pass; 0 in IDLE.
//  Stream: while stream_busy, o_stream_vld=1, o_bit_idx counts P-1 down to 0, advancing only
//   on vld&&rdy; rdy low holds index. Beat at index 0 accepted -> stream_busy=0,
//   groups_streamed++.
//  Swap: registered fill_full && !stream_busy -> next edge toggles o_read_buf, stream_busy=1,
//   o_bit_idx=P-1, fill_full=0. Exactly one bubble cycle (vld=0) between groups.
//   A row is never written to the buffer being streamed; o_mem_ready=0 while fill_full.
//  Simultaneous last-bit-accept and last-row-accept: both flags update, swap on next edge.
//  End: groups_streamed==G -> o_done=1 for one cycle, o_busy=0, state IDLE, o_read_buf kept.
//  Counter widths: bit cnt clog2(WL); win cnt clog2(PW)+1; group cnts GRP_BITS, no wrap.
// STRUCTURE
//  stripes_defs.vh: state encodings (IDLE/FILL/RUN/DRAIN), shared PW/WL/BRICKS defaults,
//   CLOG2 macro. One sub-module: dispatcher_sel_gen (combinational base/stride -> o_sel).
//  Top: FSM, win/bit/group counters, ping-pong flags. Instantiates alongside dispatcher.
// TESTING
//  T1 reset mid-RUN (rst at cycle 20) -> all outputs at reset values same cycle, no o_done.
//  T2 G=3,W=4,P=8,rdy=1,valid=1 -> 4 rows/group, 8 vld beats/group, 1 bubble, read_buf
//   toggles 3 times, o_done exactly once after 24th beat.
//  T3 base=3,stride=5,W=16 -> o_sel[w]=(3+5w)%16 (w=1:8, w=3:2, w=15:14).
//  T4 rdy held low 10 cycles mid-stream at bit_idx=5 -> bit_idx stays 5, mem_ready=0 once
//   fill_full, no row lost; resumes at 5.
//  T5 clamp: windows=0,precision=0 -> 16 rows/group, 16 beats/group; groups=0 -> o_done next
//   cycle, no mem_ready.
//  T6 i_start pulsed while busy -> ignored; config unchanged; single o_done.

Source files
------------

// File: rtl/dispatcher_ctrl_pkg.sv
// Shared sizing, FSM encodings, latched pass configuration and input clamps
// for the Stripes bit-serial dispatcher sequencer.
package dispatcher_ctrl_pkg;

  localparam int BRICKS_PER_ROW   = 16;
  localparam int PARALLEL_WINDOWS = 16;
  localparam int SEL_BITS         = 4;
  localparam int WL               = 16;
  localparam int GRP_BITS         = 12;
  localparam int WIN_BITS         = $clog2(PARALLEL_WINDOWS) + 1;
  localparam int PREC_BITS        = $clog2(WL) + 1;
  localparam int BIT_BITS         = $clog2(WL);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef struct packed {
    logic [GRP_BITS-1:0]  groups;
    logic [WIN_BITS-1:0]  windows;
    logic [PREC_BITS-1:0] precision;
    logic [SEL_BITS-1:0]  base;
    logic [SEL_BITS-1:0]  stride;
  } cfg_t;

  // Out-of-range window counts (0 or more than exist) mean "all windows".
  function automatic logic [WIN_BITS-1:0] clamp_windows(input logic [WIN_BITS-1:0] w);
    if ((w == '0) || (w > WIN_BITS'(PARALLEL_WINDOWS))) begin
      return WIN_BITS'(PARALLEL_WINDOWS);
    end else begin
      return w;
    end
  endfunction

  // Out-of-range precisions (0 or above the word length) mean full precision.
  function automatic logic [PREC_BITS-1:0] clamp_precision(input logic [PREC_BITS-1:0] p);
    if ((p == '0) || (p > PREC_BITS'(WL))) begin
      return PREC_BITS'(WL);
    end else begin
      return p;
    end
  endfunction

endpackage

// File: rtl/dispatcher_ctrl_sel_gen.sv
// Per-window brick select: window w reads brick (base + w*stride) mod BRICKS_PER_ROW.
// Driven to all-zero while the sequencer is idle.
module dispatcher_sel_gen
  import dispatcher_ctrl_pkg::*;
(
  input  logic                               i_en,
  input  logic [SEL_BITS-1:0]                i_base,
  input  logic [SEL_BITS-1:0]                i_stride,
  output logic [SEL_BITS*PARALLEL_WINDOWS-1:0] o_sel
);

  // Compute every window's brick index from the latched base and stride.
  always_comb begin
    o_sel = '0;
    for (int w = 0; w < PARALLEL_WINDOWS; w++) begin
      if (i_en) begin
        o_sel[w*SEL_BITS +: SEL_BITS] =
          SEL_BITS'((int'(i_base) + w * int'(i_stride)) % BRICKS_PER_ROW);
      end else begin
        o_sel[w*SEL_BITS +: SEL_BITS] = '0;
      end
    end
  end

endmodule

// File: rtl/dispatcher_ctrl.sv
// Stripes dispatcher sequencer: fills one transposer buffer row-by-row while the
// other streams P bit-planes, swapping the pair once a fill is complete and the
// previous stream has drained. One pass covers the latched number of groups.
module dispatcher_ctrl
  import dispatcher_ctrl_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_start,
  input  logic [GRP_BITS-1:0]                  i_groups,
  input  logic [WIN_BITS-1:0]                  i_windows,
  input  logic [PREC_BITS-1:0]                 i_precision,
  input  logic [SEL_BITS-1:0]                  i_base_brick,
  input  logic [SEL_BITS-1:0]                  i_stride,
  input  logic                                 i_mem_valid,
  output logic                                 o_mem_ready,
  output logic [SEL_BITS*PARALLEL_WINDOWS-1:0] o_sel,
  output logic [PARALLEL_WINDOWS-1:0]          o_enable,
  output logic                                 o_read_buf,
  input  logic                                 i_stream_rdy,
  output logic                                 o_stream_vld,
  output logic [BIT_BITS-1:0]                  o_bit_idx,
  output logic                                 o_busy,
  output logic                                 o_done
);

  logic [1:0]          r_state;
  cfg_t                r_cfg;
  logic [WIN_BITS-1:0] r_win_cnt;
  logic [BIT_BITS-1:0] r_bit_idx;
  logic [GRP_BITS-1:0] r_grp_loaded;
  logic [GRP_BITS-1:0] r_grp_streamed;
  logic                r_fill_full;
  logic                r_stream_busy;
  logic                r_read_buf;
  logic                r_done;

  logic w_filling;
  logic w_mem_ready;
  logic w_row_acc;
  logic w_last_row;
  logic w_beat_acc;
  logic w_last_beat;
  logic w_swap;

  // Fill is only open while a group remains to load and the fill buffer is free;
  // this is also what keeps rows out of the buffer currently being streamed.
  assign w_filling   = (r_state == ST_FILL) || (r_state == ST_RUN);
  assign w_mem_ready = w_filling && !r_fill_full && (r_grp_loaded < r_cfg.groups);
  assign w_row_acc   = w_mem_ready && i_mem_valid;
  assign w_last_row  = w_row_acc && (r_win_cnt == (r_cfg.windows - WIN_BITS'(1)));
  assign w_beat_acc  = r_stream_busy && i_stream_rdy;
  assign w_last_beat = w_beat_acc && (r_bit_idx == '0);
  assign w_swap      = r_fill_full && !r_stream_busy;

  // Window write strobe follows the accepted row directly.
  always_comb begin
    if (w_row_acc) begin
      o_enable = {{(PARALLEL_WINDOWS-1){1'b0}}, 1'b1} << r_win_cnt;
    end else begin
      o_enable = '0;
    end
  end

  // Pass sequencing: config latch, fill/stream counters, ping-pong swap and end of pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_cfg          <= '0;
      r_win_cnt      <= '0;
      r_bit_idx      <= '0;
      r_grp_loaded   <= '0;
      r_grp_streamed <= '0;
      r_fill_full    <= 1'b0;
      r_stream_busy  <= 1'b0;
      r_read_buf     <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_cfg          <= '{groups:    i_groups,
                                windows:   clamp_windows(i_windows),
                                precision: clamp_precision(i_precision),
                                base:      i_base_brick,
                                stride:    i_stride};
            r_win_cnt      <= '0;
            r_bit_idx      <= '0;
            r_grp_loaded   <= '0;
            r_grp_streamed <= '0;
            r_fill_full    <= 1'b0;
            r_stream_busy  <= 1'b0;
            if (i_groups == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= ST_FILL;
            end
          end
        end
        ST_FILL, ST_RUN, ST_DRAIN: begin
          // Fill side: one window per accepted row, buffer full after the last window.
          if (w_row_acc) begin
            if (w_last_row) begin
              r_win_cnt    <= '0;
              r_fill_full  <= 1'b1;
              r_grp_loaded <= r_grp_loaded + GRP_BITS'(1);
            end else begin
              r_win_cnt <= r_win_cnt + WIN_BITS'(1);
            end
          end
          // Stream side: swap buffers when idle with a full buffer, else count bits down.
          if (w_swap) begin
            r_read_buf    <= ~r_read_buf;
            r_stream_busy <= 1'b1;
            r_bit_idx     <= BIT_BITS'(r_cfg.precision - PREC_BITS'(1));
            r_fill_full   <= 1'b0;
            r_state       <= (r_grp_loaded == r_cfg.groups) ? ST_DRAIN : ST_RUN;
          end else if (w_last_beat) begin
            r_stream_busy  <= 1'b0;
            r_grp_streamed <= r_grp_streamed + GRP_BITS'(1);
            if ((r_grp_streamed + GRP_BITS'(1)) == r_cfg.groups) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end else if (w_beat_acc) begin
            r_bit_idx <= r_bit_idx - BIT_BITS'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  dispatcher_sel_gen u_sel_gen (
    .i_en     (r_state != ST_IDLE),
    .i_base   (r_cfg.base),
    .i_stride (r_cfg.stride),
    .o_sel    (o_sel)
  );

  assign o_mem_ready  = w_mem_ready;
  assign o_read_buf   = r_read_buf;
  assign o_stream_vld = r_stream_busy;
  assign o_bit_idx    = r_bit_idx;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = r_done;

endmodule
